// File: rtl/minitb_pkg.sv
// Shared definitions for the miniTB04 core: machine-cycle map, ALU command codes,
// instruction-register field positions and the sequencer state type.
package minitb_pkg;

    localparam logic [2:0] CYC_FETCH = 3'd0;
    localparam logic [2:0] CYC_CLEAR = 3'd1;
    localparam logic [2:0] CYC_LATCH = 3'd2;
    localparam logic [2:0] CYC_EXEC  = 3'd5;
    localparam logic [2:0] CYC_PCUPD = 3'd6;
    localparam logic [2:0] CYC_LAST  = 3'd7;

    localparam logic [3:0] CMD_ADD   = 4'b0000;
    localparam logic [3:0] CMD_SUB   = 4'b0001;
    localparam logic [3:0] CMD_AND   = 4'b0010;
    localparam logic [3:0] CMD_OR    = 4'b0011;
    localparam logic [3:0] CMD_XOR   = 4'b0100;
    localparam logic [3:0] CMD_LDI   = 4'b0101;
    localparam logic [3:0] CMD_JMP   = 4'b0110;
    localparam logic [3:0] CMD_JZ    = 4'b0111;
    localparam logic [3:0] CMD_NOP   = 4'b1000;

    localparam int IR_CMD_MSB = 7;
    localparam int IR_CMD_LSB = 4;
    localparam int IR_IMM_MSB = 3;
    localparam int IR_IMM_LSB = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM fetch and ALU command/result bundle between the sequencer (master)
// and the ROM/ALU side (slave).
interface fetch_sequencer_if #(
    parameter int PC_W = 4
) ();
    logic [PC_W-1:0] rom_addr;
    logic [7:0]      rom_data;
    logic [2:0]      cycle;
    logic [3:0]      command;
    logic [3:0]      immediate;
    logic            alu_jump;
    logic [3:0]      alu_data;

    modport master (
        output rom_addr, cycle, command, immediate,
        input  rom_data, alu_jump, alu_data
    );

    modport slave (
        input  rom_addr, cycle, command, immediate,
        output rom_data, alu_jump, alu_data
    );
endinterface

// File: rtl/fetch_sequencer_cycle_counter.sv
// 3-bit machine-cycle counter: wraps 7 -> 0, counts while en, synchronous clear.
module cycle_counter
    import minitb_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] count,
    output logic       tc
);
    logic [2:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= CYC_FETCH;
        end else if (en) begin
            count_reg <= count_reg + 3'd1;
        end
    end

    assign count = count_reg;
    assign tc    = (count_reg == CYC_LAST);
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for miniTB04: owns pc, IR and the machine cycle.
// Optional single-instruction stepping is enabled by defining SINGLE_STEP_EN.
module fetch_sequencer
    import minitb_pkg::*;
#(
    parameter int         PC_W     = 4,
    parameter logic [7:0] IR_RESET = 8'h80
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            step,
    fetch_sequencer_if.master bus,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            instr_done
);
    seq_state_t      state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [7:0]      ir_reg;
    logic            done_reg;
    logic            single_reg;
    logic [2:0]      cycle;
    logic            last_cycle;
    logic            start_step;
    logic [PC_W-1:0] jump_target;

`ifdef SINGLE_STEP_EN
    assign start_step = step & ~run;
`else
    // Step is part of the port list in every build but has no effect here.
    assign start_step = step & 1'b0;
`endif

    // Jump target is alu_data zero-extended or truncated to the pc width.
    for (genvar gi = 0; gi < PC_W; gi++) begin : g_jump_target
        if (gi < 4) begin : g_data
            assign jump_target[gi] = bus.alu_data[gi];
        end else begin : g_zero
            assign jump_target[gi] = 1'b0;
        end
    end

    cycle_counter u_cycle_counter (
        .clk   (clk),
        .clr   (reset),
        .en    (state_reg == ST_RUN),
        .count (cycle),
        .tc    (last_cycle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= '0;
            ir_reg     <= IR_RESET;
            done_reg   <= 1'b0;
            single_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (run) begin
                        state_reg  <= ST_RUN;
                        single_reg <= 1'b0;
                    end else if (start_step) begin
                        state_reg  <= ST_RUN;
                        single_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cycle == CYC_LATCH) begin
                        ir_reg <= bus.rom_data;
                    end
                    // done is registered here so it is high throughout cycle 7.
                    if (cycle == CYC_PCUPD) begin
                        pc_reg   <= bus.alu_jump ? jump_target : pc_reg + PC_W'(1);
                        done_reg <= 1'b1;
                    end
                    if (last_cycle && (single_reg || !run)) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign pc            = pc_reg;
    assign bus.rom_addr  = pc_reg;
    assign bus.cycle     = cycle;
    assign bus.command   = ir_reg[IR_CMD_MSB:IR_CMD_LSB];
    assign bus.immediate = ir_reg[IR_IMM_MSB:IR_IMM_LSB];
    assign busy          = (state_reg == ST_RUN);
    assign instr_done    = done_reg;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: the bench plays both program ROM and ALU.
module tb_fetch_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic [3:0] pc;
    logic       busy;
    logic       instr_done;
    logic [7:0] rom [16];
    int         n_cmp = 0;
    int         n_err = 0;
    int         pulses;

    fetch_sequencer_if #(.PC_W(4)) bus ();

    fetch_sequencer #(.PC_W(4), .IR_RESET(8'h80)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .bus        (bus),
        .pc         (pc),
        .busy       (busy),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_to_cycle(input logic [2:0] c);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.cycle !== c && n < 16);
        chk("reach_cycle", 32'(bus.cycle), 32'(c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rom[0] = 8'h35;
        rom[1] = 8'h12;
        for (int i = 2; i < 16; i++) rom[i] = {4'(i), 4'(15 - i)};
        reset = 1'b1; run = 1'b1; step = 1'b0;
        bus.alu_jump = 1'b0; bus.alu_data = 4'h0;

        // Reset wins over run
        repeat (3) tick();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_cycle", 32'(bus.cycle), 32'h0);
        chk("rst_cmd", 32'(bus.command), 32'h8);
        chk("rst_imm", 32'(bus.immediate), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(instr_done), 32'h0);
        $display("txn reset: pc=%0h cycle=%0d cmd=%0h", pc, bus.cycle, bus.command);

        // Linear fetch from ROM[0], ROM[1]
        reset = 1'b0;
        tick();
        chk("start_cycle", 32'(bus.cycle), 32'h0);
        chk("start_busy", 32'(busy), 32'h1);
        tick();
        chk("second_clk_cycle", 32'(bus.cycle), 32'h1);
        tick();
        chk("pre_latch_cmd", 32'(bus.command), 32'h8);
        tick();
        chk("latch_cmd0", 32'(bus.command), 32'h3);
        chk("latch_imm0", 32'(bus.immediate), 32'h5);
        run_to_cycle(3'd6);
        chk("pc_before_upd", 32'(pc), 32'h0);
        tick();
        chk("pc_after_upd", 32'(pc), 32'h1);
        chk("done_c7", 32'(instr_done), 32'h1);
        tick();
        chk("done_c0", 32'(instr_done), 32'h0);
        chk("rom_addr", 32'(bus.rom_addr), 32'h1);
        run_to_cycle(3'd3);
        chk("latch_cmd1", 32'(bus.command), 32'h1);
        chk("latch_imm1", 32'(bus.immediate), 32'h2);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (instr_done) pulses++;
        end
        chk("done_per_8", 32'(pulses), 32'h1);
        $display("txn linear: pc=%0h pulses=%0d", pc, pulses);

        // Jump flag outside cycle 6 is ignored (instruction at pc=2)
        run_to_cycle(3'd4);
        bus.alu_jump = 1'b1; bus.alu_data = 4'h7;
        tick();
        bus.alu_jump = 1'b0;
        run_to_cycle(3'd7);
        chk("jump_ignored_pc", 32'(pc), 32'h3);

        // Jump taken in cycle 6 (instruction at pc=3)
        run_to_cycle(3'd6);
        bus.alu_jump = 1'b1; bus.alu_data = 4'hA;
        tick();
        bus.alu_jump = 1'b0;
        chk("jump_pc", 32'(pc), 32'hA);
        $display("txn jump: pc=%0h", pc);

        // Jump to 15, then wrap to 0 with no jump
        run_to_cycle(3'd6);
        bus.alu_jump = 1'b1; bus.alu_data = 4'hF;
        tick();
        bus.alu_jump = 1'b0;
        chk("jump15_pc", 32'(pc), 32'hF);
        run_to_cycle(3'd2);
        chk("hold_cmd_c2", 32'({bus.command, bus.immediate}), 32'(rom[10]));
        tick();
        chk("latch_cmd15", 32'({bus.command, bus.immediate}), 32'(rom[15]));
        run_to_cycle(3'd7);
        chk("wrap_pc", 32'(pc), 32'h0);
        $display("txn wrap: pc=%0h", pc);

        // Run dropped at cycle 3: instruction completes, then IDLE
        run_to_cycle(3'd3);
        run = 1'b0;
        run_to_cycle(3'd7);
        chk("drop_done", 32'(instr_done), 32'h1);
        chk("drop_pc", 32'(pc), 32'h1);
        tick();
        chk("drop_busy", 32'(busy), 32'h0);
        repeat (3) tick();
        chk("idle_cycle", 32'(bus.cycle), 32'h0);
        chk("idle_pc", 32'(pc), 32'h1);
        chk("idle_busy", 32'(busy), 32'h0);
        $display("txn run_drop: pc=%0h busy=%0b", pc, busy);

`ifdef SINGLE_STEP_EN
        // One step runs exactly one instruction; a step while busy is ignored
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step_busy", 32'(busy), 32'h1);
        chk("step_cycle", 32'(bus.cycle), 32'h0);
        run_to_cycle(3'd4);
        step = 1'b1;
        tick();
        step = 1'b0;
        run_to_cycle(3'd7);
        chk("step_pc", 32'(pc), 32'h2);
        chk("step_done", 32'(instr_done), 32'h1);
        tick();
        chk("step_idle", 32'(busy), 32'h0);
        repeat (4) tick();
        chk("step_not_queued", 32'(busy), 32'h0);
        $display("txn step: pc=%0h busy=%0b", pc, busy);
`else
        // Step has no effect in the default build
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("step_ignored_busy", 32'(busy), 32'h0);
        chk("step_ignored_cycle", 32'(bus.cycle), 32'h0);
        $display("txn step_ignored: busy=%0b", busy);
`endif

        // run and step together: continuous mode
        run = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        run_to_cycle(3'd7);
        tick();
        chk("cont_busy", 32'(busy), 32'h1);

        // Reset mid-instruction abandons it
        run_to_cycle(3'd4);
        run = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_pc", 32'(pc), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_cycle", 32'(bus.cycle), 32'h0);
        chk("midrst_cmd", 32'(bus.command), 32'h8);
        tick();
        chk("midrst_idle", 32'(busy), 32'h0);
        $display("txn mid_reset: pc=%0h busy=%0b", pc, busy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
